// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the sequential subtractor and its companion adder.
//   - state enum for the multi-cycle datapath
//   - bias / all-ones exponent constants for the default format
//   - fp_t word layout {sign, exp, frac}, sized by FP_EXP_WIDTH / FP_MANTISSA_WIDTH macros
//   - exp_max(): all-ones exponent value for an arbitrary exponent width
`ifndef FP_EXP_WIDTH
`define FP_EXP_WIDTH 8
`endif
`ifndef FP_MANTISSA_WIDTH
`define FP_MANTISSA_WIDTH 23
`endif

package fp_pkg;

    localparam int FP_E       = `FP_EXP_WIDTH;
    localparam int FP_M       = `FP_MANTISSA_WIDTH;
    localparam int FP_BIAS    = (1 << (FP_E - 1)) - 1;
    localparam int FP_EXP_MAX = (1 << FP_E) - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_PACK  = 3'd4
    } fps_state_e;

    typedef struct packed {
        logic                          sign;
        logic [`FP_EXP_WIDTH-1:0]      exp;
        logic [`FP_MANTISSA_WIDTH-1:0] frac;
    } fp_t;

    function automatic int unsigned exp_max(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits a floating-point word into its fields.
// A zero exponent is treated as zero: the hidden bit is cleared and any
// denormal fraction is flushed, so mant is all zeros for such operands.
//   word    : {sign, exp, frac}
//   sign    : sign bit
//   exp     : raw biased exponent
//   mant    : {hidden, frac}, zero when exp == 0
//   is_zero : exp == 0
module fp_unpack #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] word,
    output logic                              sign,
    output logic [EXP_WIDTH-1:0]              exp,
    output logic [MANTISSA_WIDTH:0]           mant,
    output logic                              is_zero
);

    always_comb begin
        sign    = word[EXP_WIDTH+MANTISSA_WIDTH];
        exp     = word[EXP_WIDTH+MANTISSA_WIDTH-1:MANTISSA_WIDTH];
        is_zero = (exp == '0);
        mant    = is_zero ? '0 : {1'b1, word[MANTISSA_WIDTH-1:0]};
    end

endmodule

// File: rtl/fp_seq_subtractor.sv
// Multi-cycle floating-point subtractor: fps_out = a_in - b_in.
// Optional build macro: FPS_ROUND_NEAREST_EN (round to nearest-even with a
// sticky bit instead of truncating the guard bits).
//   clk_in        : clock, rising edge
//   reset_in      : asynchronous active-high reset
//   start_in      : request, sampled only in IDLE
//   a_in, b_in    : minuend / subtrahend {sign, exp, frac}
//   busy_out      : high in every state except IDLE
//   done_out      : one-cycle pulse when a new result is valid
//   fps_out       : result, held until the next completed operation
//   overflow_out  : result exponent reached all-ones
//   underflow_out : nonzero result fell below the smallest normal exponent
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start_in; operands captured and ordered on start
// ST_ALIGN | small mantissa shifted right one bit per cycle
// ST_ADD   | magnitudes added or subtracted
// ST_NORM  | carry shifted out, or leading one shifted up one bit per cycle
// ST_PACK  | result and flags registered
module fp_seq_subtractor
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic                              clk_in,
    input  logic                              reset_in,
    input  logic                              start_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
    output logic                              busy_out,
    output logic                              done_out,
    output logic [EXP_WIDTH+MANTISSA_WIDTH:0] fps_out,
    output logic                              overflow_out,
    output logic                              underflow_out
);

    localparam int E   = EXP_WIDTH;
    localparam int M   = MANTISSA_WIDTH;
    localparam int W   = 1 + E + M;
    localparam int MW  = M + 3;                 // hidden + fraction + 2 guard bits
    localparam int CW  = $clog2(MW + 1);
    // Wide enough to hold all-ones + 1 and to go below zero by a full normalisation.
    localparam int EXW = ((E > $clog2(MW + 1)) ? E : $clog2(MW + 1)) + 2;
    localparam logic signed [EXW-1:0] EXP_ALL = EXW'(exp_max(E));

    fps_state_e state, state_nxt;

    logic          a_sign, b_sign, a_zero, b_zero;
    logic [E-1:0]  a_exp, b_exp;
    logic [M:0]    a_mant, b_mant;

    logic          a_is_big;
    logic [E-1:0]  exp_diff;
    logic [CW-1:0] align_load;

    logic                  res_sign;
    logic signed [EXW-1:0] res_exp;
    logic [MW-1:0]         big_mant, small_mant;
    logic                  eff_sub;
    logic [CW-1:0]         align_cnt;
    logic [MW:0]           sum;
    logic                  done_pend;

    logic signed [EXW-1:0] pack_exp;
    logic [M-1:0]          pack_frac;
    logic [W-1:0]          pack_word;
    logic                  pack_ovf, pack_unf;

`ifdef FPS_ROUND_NEAREST_EN
    logic       sticky;
    logic       round_up;
    logic [M+1:0] mant_rnd;
`endif

    fp_unpack #(.EXP_WIDTH(E), .MANTISSA_WIDTH(M)) u_unpack_a (
        .word    (a_in),
        .sign    (a_sign),
        .exp     (a_exp),
        .mant    (a_mant),
        .is_zero (a_zero)
    );

    fp_unpack #(.EXP_WIDTH(E), .MANTISSA_WIDTH(M)) u_unpack_b (
        .word    (b_in),
        .sign    (b_sign),
        .exp     (b_exp),
        .mant    (b_mant),
        .is_zero (b_zero)
    );

    // Operand ordering by magnitude; a zero operand always ranks lowest.
    always_comb begin
        a_is_big = ((a_zero ? {(E+M){1'b0}} : {a_exp, a_mant[M-1:0]}) >=
                    (b_zero ? {(E+M){1'b0}} : {b_exp, b_mant[M-1:0]}));
        exp_diff = a_is_big ? (a_exp - b_exp) : (b_exp - a_exp);
        if (32'(exp_diff) > 32'(MW)) begin
            align_load = CW'(MW);
        end else begin
            align_load = CW'(exp_diff);
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_in) state_nxt = ST_ALIGN;
            ST_ALIGN: if (align_cnt <= CW'(1)) state_nxt = ST_ADD;
            ST_ADD:   state_nxt = ST_NORM;
            // Leave when the carry is handled, the sum is zero, or the hidden
            // position is (or will be after this shift) set.
            ST_NORM:  if (sum[MW] || (sum == '0) || sum[MW-1] || sum[MW-2])
                          state_nxt = ST_PACK;
            ST_PACK:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state != ST_IDLE);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            res_sign   <= 1'b0;
            res_exp    <= '0;
            big_mant   <= '0;
            small_mant <= '0;
            eff_sub    <= 1'b0;
            align_cnt  <= '0;
            sum        <= '0;
`ifdef FPS_ROUND_NEAREST_EN
            sticky     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start_in) begin
                    // b enters with its sign inverted; the result takes the big operand's sign.
                    res_sign   <= a_is_big ? a_sign : ~b_sign;
                    res_exp    <= EXW'(a_is_big ? a_exp : b_exp);
                    big_mant   <= {(a_is_big ? a_mant : b_mant), 2'b00};
                    small_mant <= {(a_is_big ? b_mant : a_mant), 2'b00};
                    // Like-signed raw operands become a magnitude subtraction.
                    eff_sub    <= (a_sign == b_sign);
                    align_cnt  <= align_load;
`ifdef FPS_ROUND_NEAREST_EN
                    sticky     <= 1'b0;
`endif
                end
                ST_ALIGN: if (align_cnt != '0) begin
                    small_mant <= small_mant >> 1;
                    align_cnt  <= align_cnt - CW'(1);
`ifdef FPS_ROUND_NEAREST_EN
                    sticky     <= sticky | small_mant[0];
`endif
                end
                ST_ADD: begin
                    sum <= eff_sub ? ({1'b0, big_mant} - {1'b0, small_mant})
                                   : ({1'b0, big_mant} + {1'b0, small_mant});
                end
                ST_NORM: begin
                    if (sum[MW]) begin
                        sum     <= sum >> 1;
                        res_exp <= res_exp + EXW'(1);
`ifdef FPS_ROUND_NEAREST_EN
                        sticky  <= sticky | sum[0];
`endif
                    end else if ((sum != '0) && !sum[MW-1]) begin
                        sum     <= sum << 1;
                        res_exp <= res_exp - EXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pack_exp  = res_exp;
        pack_frac = sum[MW-2:2];
`ifdef FPS_ROUND_NEAREST_EN
        round_up  = sum[1] & (sum[0] | sticky | sum[2]);
        mant_rnd  = {1'b0, sum[MW-1:2]} + (M+2)'(round_up);
        if (mant_rnd[M+1]) begin
            // Rounding carried past the hidden bit: mantissa becomes 1.0, exponent +1.
            pack_exp  = res_exp + EXW'(1);
            pack_frac = '0;
        end else begin
            pack_frac = mant_rnd[M-1:0];
        end
`endif
        pack_word = {res_sign, pack_exp[E-1:0], pack_frac};
        pack_ovf  = 1'b0;
        pack_unf  = 1'b0;
        if (sum == '0) begin
            pack_word = '0;
        end else if (pack_exp >= EXP_ALL) begin
            pack_word = {res_sign, {E{1'b1}}, {M{1'b0}}};
            pack_ovf  = 1'b1;
        end else if (pack_exp <= 0) begin
            pack_word = {res_sign, {(W-1){1'b0}}};
            pack_unf  = 1'b1;
        end
    end

    // Result registers update on the PACK edge; done follows one edge later,
    // in IDLE, so the pulse marks a result that is already stable.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            fps_out       <= '0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
            done_pend     <= 1'b0;
            done_out      <= 1'b0;
        end else begin
            done_pend <= (state == ST_PACK);
            done_out  <= done_pend;
            if (state == ST_PACK) begin
                fps_out       <= pack_word;
                overflow_out  <= pack_ovf;
                underflow_out <= pack_unf;
            end
        end
    end

endmodule

// File: tb/tb_fp_seq_subtractor.sv
// Bench for fp_seq_subtractor (default E=8, M=23): directed vectors with
// literal expectations, plus a bench-side arithmetic model checked every cycle.
module tb_fp_seq_subtractor;
    import fp_pkg::*;

    localparam int E = 8;
    localparam int M = 23;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy_out, done_out, overflow_out, underflow_out;
    logic [31:0] fps_out;

    always #5 clk = ~clk;

    fp_seq_subtractor #(.EXP_WIDTH(E), .MANTISSA_WIDTH(M)) dut (
        .clk_in        (clk),
        .reset_in      (reset_in),
        .start_in      (start_in),
        .a_in          (a_in),
        .b_in          (b_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .fps_out       (fps_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ov;
        logic        uf;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        ov;
        logic        uf;
        int          lat;
    } res_t;

    vec_t vt [11];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   armed    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Real-number subtraction with the unit's precision rules: exp 0 is zero,
    // M+2 guard-extended mantissas, alignment shift capped at M+3, truncation.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t   o;
        fp_t    fa, fb;
        logic   sa, sb, s_big, s_sm;
        int     e_big, e_sm, d, sh, e, k, n_a, n_k;
        longint ka, kb, m_big, m_sm, mag, ma, mb;
        fa = a;
        fb = b;
        sa = fa.sign;
        sb = ~fb.sign;
        ma = (fa.exp == 0) ? 0 : (((longint'(1) << M) + longint'(fa.frac)) * 4);
        mb = (fb.exp == 0) ? 0 : (((longint'(1) << M) + longint'(fb.frac)) * 4);
        ka = (fa.exp == 0) ? 0 : longint'(a[30:0]);
        kb = (fb.exp == 0) ? 0 : longint'(b[30:0]);
        if (ka >= kb) begin
            s_big = sa; e_big = int'(fa.exp); m_big = ma;
            s_sm  = sb; e_sm  = int'(fb.exp); m_sm  = mb;
        end else begin
            s_big = sb; e_big = int'(fb.exp); m_big = mb;
            s_sm  = sa; e_sm  = int'(fa.exp); m_sm  = ma;
        end
        d    = e_big - e_sm;
        sh   = (d < M + 3) ? d : M + 3;
        m_sm = m_sm / (longint'(1) << sh);
        n_a  = (sh < 1) ? 1 : sh;
        mag  = (s_big == s_sm) ? (m_big + m_sm) : (m_big - m_sm);
        e    = e_big;
        if (mag == 0) begin
            n_k = 1;
        end else if (mag >= (longint'(1) << (M + 3))) begin
            mag = mag / 2;
            e   = e + 1;
            n_k = 1;
        end else begin
            k = 0;
            while (mag < (longint'(1) << (M + 2))) begin
                mag = mag * 2;
                e   = e - 1;
                k++;
            end
            n_k = (k < 1) ? 1 : k;
        end
        o.ov = 1'b0;
        o.uf = 1'b0;
        if (mag == 0) begin
            o.r = 32'h0;
        end else if (e >= 255) begin
            o.r  = {s_big, 8'hFF, 23'h0};
            o.ov = 1'b1;
        end else if (e <= 0) begin
            o.r  = {s_big, 31'h0};
            o.uf = 1'b1;
        end else begin
            o.r = {s_big, 8'(e), 23'((mag / 4) % (longint'(1) << M))};
        end
        o.lat = 3 + n_a + n_k;
        return o;
    endfunction

    // Cycle-by-cycle comparison against the model. cyc counts edges after the
    // edge that sampled start: busy through lat-2, new result from lat-1, done at lat.
    bit          inflight = 0;
    bit          acc_pend = 0;
    int          cyc = 0;
    res_t        cur, pend;
    logic [31:0] held_r  = '0;
    logic        held_ov = 1'b0;
    logic        held_uf = 1'b0;

    always @(negedge clk) begin
        if (armed) begin
            if (reset_in) begin
                inflight = 0;
                acc_pend = 0;
                held_r   = '0;
                held_ov  = 1'b0;
                held_uf  = 1'b0;
                chk("rst_fps",  64'(fps_out), 64'(0));
                chk("rst_ovf",  64'(overflow_out), 64'(0));
                chk("rst_unf",  64'(underflow_out), 64'(0));
                chk("rst_busy", 64'(busy_out), 64'(0));
                chk("rst_done", 64'(done_out), 64'(0));
            end else begin
                if (inflight) cyc++;
                if (acc_pend) begin
                    inflight = 1;
                    cyc      = 0;
                    cur      = pend;
                    acc_pend = 0;
                end
                if (inflight) begin
                    chk("busy", 64'(busy_out), 64'(cyc <= cur.lat - 2));
                    chk("done", 64'(done_out), 64'(cyc == cur.lat));
                    chk("fps",  64'(fps_out),       64'((cyc >= cur.lat - 1) ? cur.r  : held_r));
                    chk("ovf",  64'(overflow_out),  64'((cyc >= cur.lat - 1) ? cur.ov : held_ov));
                    chk("unf",  64'(underflow_out), 64'((cyc >= cur.lat - 1) ? cur.uf : held_uf));
                    if (cyc >= cur.lat) begin
                        held_r   = cur.r;
                        held_ov  = cur.ov;
                        held_uf  = cur.uf;
                        inflight = 0;
                    end
                end else begin
                    chk("busy_idle", 64'(busy_out), 64'(0));
                    chk("done_idle", 64'(done_out), 64'(0));
                    chk("fps_hold",  64'(fps_out), 64'(held_r));
                    chk("ovf_hold",  64'(overflow_out), 64'(held_ov));
                    chk("unf_hold",  64'(underflow_out), 64'(held_uf));
                end
                if (start_in && (!inflight || cyc >= cur.lat - 1)) begin
                    pend     = model(a_in, b_in);
                    acc_pend = 1;
                end
            end
        end
    end

    task automatic run_vec(input int idx);
        bit got;
        @(posedge clk); #2;
        a_in     = vt[idx].a;
        b_in     = vt[idx].b;
        start_in = 1'b1;
        @(posedge clk); #2;
        start_in = 1'b0;
        got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (done_out === 1'b1) got = 1;
        end
        if (got) begin
            chk($sformatf("lit_fps[%0d]", idx), 64'(fps_out), 64'(vt[idx].r));
            chk($sformatf("lit_flags[%0d]", idx), 64'({overflow_out, underflow_out}),
                64'({vt[idx].ov, vt[idx].uf}));
        end else begin
            n_checks++;
            $display("FAIL timeout[%0d]: no done_out within 100 cycles, expected after %0d",
                     idx, vt[idx].lat);
        end
    endtask

    initial begin
        res_t m;
        vt[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 5};
        vt[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 5};
        vt[2]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 5};
        vt[3]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0, 5};
        vt[4]  = '{32'h3F800000, 32'h3F400000, 32'h3E800000, 1'b0, 1'b0, 6};
        vt[5]  = '{32'h4B800000, 32'h3F800000, 32'h4B7FFFFF, 1'b0, 1'b0, 28};
        vt[6]  = '{32'h3FC00000, 32'h00000000, 32'h3FC00000, 1'b0, 1'b0, 30};
        vt[7]  = '{32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 30};
        vt[8]  = '{32'h40A00000, 32'h40400000, 32'h40000000, 1'b0, 1'b0, 5};
        vt[9]  = '{32'h00800000, 32'h00C00000, 32'h80000000, 1'b0, 1'b1, 5};
        vt[10] = '{32'h4B000000, 32'h3F800000, 32'h4AFFFFFE, 1'b0, 1'b0, 27};

        for (int i = 0; i < 11; i++) begin
            m = model(vt[i].a, vt[i].b);
            chk($sformatf("model[%0d]", i), {m.r, m.ov, m.uf, 30'(m.lat)},
                {vt[i].r, vt[i].ov, vt[i].uf, 30'(vt[i].lat)});
        end

        repeat (2) @(posedge clk);
        #1 armed = 1;
        @(posedge clk); #2;
        reset_in = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Abort mid-ALIGN: start, an ignored re-pulse, then reset.
        @(posedge clk); #2;
        a_in     = vt[10].a;
        b_in     = vt[10].b;
        start_in = 1'b1;
        @(posedge clk); #2;
        start_in = 1'b0;
        repeat (3) @(posedge clk);
        #2 start_in = 1'b1;
        @(posedge clk); #2;
        start_in = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_in = 1'b1;
        #1;
        chk("abort_fps",  64'(fps_out), 64'(0));
        chk("abort_unf",  64'(underflow_out), 64'(0));
        chk("abort_busy", 64'(busy_out), 64'(0));
        chk("abort_done", 64'(done_out), 64'(0));
        repeat (2) @(posedge clk);
        #2 reset_in = 1'b0;
        repeat (40) @(posedge clk);

        run_vec(0);
        run_vec(10);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_seq_subtractor.md
# fp_seq_subtractor

Multi-cycle floating-point subtractor computing a_in − b_in for the same parameterised sign/exponent/mantissa format used by the floating-point adder. It is the subtraction-direction companion of the combinational adder. Operands are captured on a start handshake, then aligned and normalised one bit per clock. The result is presented with a one-cycle done pulse. It sits beside the adder in the floating-point datapath and in benches that drive both units from the same operand stream.

## Interface
- EXP_WIDTH, 8: exponent field width E; bias = 2^(E−1)−1.
- MANTISSA_WIDTH, 23: stored fraction width M; a hidden bit is implied. Word width W = 1+E+M.
- clk_in  input  1  single clock; everything is rising-edge.
- reset_in  input  1  asynchronous, active-high reset.
- start_in  input  1  request; sampled only in IDLE.
- a_in  input  W  minuend {sign, exp, frac}.
- b_in  input  W  subtrahend.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  one-cycle pulse when a new result is valid.
- fps_out  output  W  result; held until the next completed operation.
- overflow_out  output  1  result exceeded the largest finite exponent; held with fps_out.
- underflow_out  output  1  nonzero result fell below the smallest normal exponent; held with fps_out.

## Operation
- Reset clears all outputs to 0 and sets the state to IDLE.
- States are IDLE → ALIGN → ADD → NORM → PACK → IDLE.
- **IDLE**
  - On start_in=1, capture the operands and invert the sign of b.
  - Order the operands by magnitude, then go to ALIGN.
  - start_in during any other state is ignored and not queued.
- **Operands**
  - exp=0 means zero; the hidden bit is 0 and denormals are flushed.
  - exp=all-ones gets no special handling; Inf/NaN are unsupported.
- **Internal mantissa:** M+3 bits, made of hidden + M fraction + 2 guard bits.
- **ALIGN:** shift the small mantissa right one bit per cycle. This takes max(1, min(d, M+3)) cycles, where d is the exponent difference.
- **ADD**
  - Same effective signs: add the magnitudes.
  - Different effective signs: subtract small from big.
  - The result sign is the big operand's sign.
- **NORM**
  - Carry out: shift right once, exponent +1, one cycle.
  - Zero magnitude: leave NORM in one cycle.
  - Otherwise: shift left one bit per cycle, decrementing the exponent, until the hidden position is 1. This takes max(1, k) cycles for k shifts.
- **PACK:** register the result and flags, pulse done_out, return to IDLE.
  - Overflow: exponent ≥ all-ones gives {sign, all-ones, 0} and overflow_out=1.
  - Underflow: exponent ≤ 0 on a nonzero magnitude gives signed zero and underflow_out=1.
  - Exact cancellation gives +0 with no flags.
  - Rounding is truncation of the guard bits.

## Timing
- Latency from the edge that samples start_in to the edge that raises done_out is 3 + max(1, min(d, M+3)) + max(1, k) cycles. The minimum is 5.
- done_out is high for exactly one cycle, and busy_out is 0 in that cycle.
- start_in high in the done cycle is accepted.
- fps_out and the flags change only on the PACK edge.
- reset_in mid-operation aborts immediately: outputs go to 0 and no done pulse is produced.

## Configuration
- FPS_ROUND_NEAREST_EN
  - Defined: PACK rounds to nearest-even using the guard bits plus a sticky bit ORed from bits shifted out in ALIGN. A rounding carry renormalises within PACK: exponent +1, which may set overflow. Latency is unchanged.
  - Undefined: truncation, no sticky logic.

## Structure
- Shared package fp_pkg holds:
  - the state enum;
  - the bias and EXP_MAX constants;
  - a packed fp_t struct {sign, exp, frac}, parameterised via macros over EXP_WIDTH and MANTISSA_WIDTH.
- One sub-module, fp_unpack (combinational): splits a word into sign, exponent, mantissa-with-hidden-bit and an is_zero flag. It is instantiated twice.

## Test plan
Defaults E=8, M=23.
- 0x40400000 − 0x3F800000 (3−1) → fps_out=0x40000000, no flags, done_out exactly 5 cycles after start.
- 0x3F800000 − 0x3F800000 → 0x00000000, no flags.
- 0x3F800000 − 0xBF800000 (1−(−1)) → 0x40000000 via the carry path in NORM.
- 0x7F7FFFFF − 0xFF7FFFFF → 0x7F800000, overflow_out=1.
- 0x00800000 − 0x00C00000 → 0x80000000, underflow_out=1.
- Start 0x4B000000 − 0x3F800000, re-pulse start while busy (ignored), then assert reset_in in ALIGN:
  - all outputs go to 0 and no done pulse occurs;
  - after release, a new start completes normally.
